branch_unit_bht: RTL and testbench
==================================

Name: branch_unit_bht

Overview:
- Next-generation branch resolution unit for the RV32I core's EX stage.
- Evaluates the condition for BEQ/BNE/BLT/BGE/BLTU/BGEU from ALU flags.
- Compares the outcome against the fetch-stage prediction and issues a registered flush/redirect.
- Maintains a parametrised branch history table (BHT) of saturating counters, with a combinational prediction read port for IF and saturating statistics counters.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, BHT index width; table depth = 2**IDX_W entries.
- CNT_W, 2, saturating counter width per BHT entry (must be >= 1).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- if_pc  input  PC_W  fetch PC for prediction lookup.
- if_pred_taken  output  1  combinational prediction: MSB of BHT[if_pc[IDX_W+1:2]].
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_branch  input  1  instruction is a conditional branch.
- ex_kill  input  1  EX instruction is being squashed; suppresses all effects.
- ex_funct3  input  3  branch funct3.
- ex_zero  input  1  ALU zero flag (rs1 == rs2).
- ex_s_less  input  1  signed rs1 < rs2.
- ex_u_less  input  1  unsigned rs1 < rs2.
- ex_pc  input  PC_W  PC of the EX branch (BHT update index).
- ex_pred_taken  input  1  prediction carried down the pipeline with this branch.
- ex_target  input  PC_W  taken target.
- ex_pc_plus4  input  PC_W  fall-through address.
- cnd  output  1  registered resolved outcome.
- flush  output  1  registered one-cycle mispredict pulse.
- redirect_pc  output  PC_W  registered correct next PC; meaningful when flush=1.
- illegal  output  1  registered one-cycle pulse for a reserved funct3.
- stat_branches  output  STAT_W  count of resolved branches.
- stat_mispredicts  output  STAT_W  count of mispredictions.

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset values:
  - cnd, flush, illegal, redirect_pc and both stats are 0.
  - Every BHT entry is 2**(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2).
- Resolve event: ex_valid & ex_branch & ~ex_kill.
- Condition evaluation (combinational, internal), selected by funct3[2:1]:
  - 00: cnd_c = funct3[0] ^ zero.
  - 10: cnd_c = funct3[0] ^ s_less.
  - 11: cnd_c = funct3[0] ^ u_less.
  - 01: reserved; cnd_c = 0, legal_c = 0.
- Latency: all outputs are registered; a resolve at edge N is visible after edge N (one cycle).
- On a legal resolve edge:
  - cnd <= cnd_c.
  - flush <= (cnd_c != ex_pred_taken).
  - redirect_pc <= cnd_c ? ex_target : ex_pc_plus4.
  - stat_branches increments; stat_mispredicts increments when flush is set.
  - Both stats saturate at all-ones with no wrap.
- On a reserved-funct3 resolve edge:
  - illegal <= 1; flush <= 0; cnd <= 0.
  - No BHT update, no stats change.
- No resolve event: flush, illegal and cnd <= 0; redirect_pc holds its value.
- BHT update: index = ex_pc[IDX_W+1:2]. Taken increments, not-taken decrements.
  - Saturates at 0 and 2**CNT_W-1; no wrap.
- BHT read/write collision: same index and same cycle, if_pred_taken returns the pre-update value (no bypass). The write lands at the edge.
- ex_kill has priority over everything: no state change, and all pulse outputs are 0 next cycle.
- Back-to-back resolves on consecutive cycles are fully supported. Each sees the BHT state left by the previous edge.
- Reset mid-operation clears the whole table and all outputs immediately (asynchronously). No pending flush survives reset.
- X-safety: no output may become X for any funct3 value.

Decomposition:
- Shared package (rv_branch_pkg) holds:
  - funct3 localparams: F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - BHT reset-value function of CNT_W.
  - Saturating inc/dec function.
- Sub-module bht_table (parameters IDX_W, CNT_W) provides:
  - Flop array with async reset.
  - One combinational read port and one write-enable update port with a taken bit.
  - Saturation performed inside the sub-module.
- The top level holds condition evaluation, output registers and stats.

Test Plan:
- Reset, then read if_pc=0x40: if_pred_taken=0. Resolve BEQ at pc 0x40 with zero=1, pred=0, target=0x80.
  - Next cycle: cnd=1, flush=1, redirect_pc=0x80, stat_mispredicts=1.
  - Entry 16 = 10; if_pred_taken(0x40)=1.
- Saturation: three taken BNE (zero=0) at pc 0x8 leave the entry at 11; a fourth taken keeps 11. Then four not-taken leave 00, and a fifth keeps 00.
- Condition table sweep: all six legal funct3 over all 8 flag combinations match the rules above.
  - Example: BGEU with u_less=1 gives cnd=0; with pred=0, flush=0 and redirect_pc=ex_pc_plus4.
- Reserved funct3=010 and 011 with ex_valid=1: illegal pulses for exactly 1 cycle; flush=0; stats and BHT are unchanged.
- ex_kill=1 during a mispredicting BLT: flush stays 0 and no stat or BHT change. A simultaneous IF read and EX update at the same index returns the old value, and the new value appears the following cycle.
- Stats saturation and mid-operation reset:
  - With STAT_W=4, 20 mispredicting branches leave both stats at 15.
  - Asserting rst_n=0 mid-cycle clears the stats and flush asynchronously, and restores the BHT entries to 01.

Source files
------------

// File: rtl/rv_branch_pkg.sv
// Shared branch-unit definitions: funct3 encodings and BHT counter helpers.
package rv_branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic int unsigned bht_rst_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned sat_step(input int unsigned val,
                                           input int unsigned max_val,
                                           input logic        up);
    if (up) return (val == max_val) ? val : val + 32'd1;
    return (val == 32'd0) ? val : val - 32'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of saturating counters: one comb read port, one update port.
module bht_table
  import rv_branch_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned DEPTH   = 32'd1 << IDX_W;
  localparam int unsigned MAX_CNT = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(bht_rst_val(CNT_W));

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];

  // Reads see the pre-update table; the write lands at the edge.
  assign rd_taken_c = cnt_q[rd_idx][CNT_W-1];

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d[wr_idx] = CNT_W'(sat_step(32'(cnt_q[wr_idx]), MAX_CNT, wr_taken));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) cnt_q[i] <= RST_CNT;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_unit_bht.sv
// EX-stage branch resolution with registered flush/redirect, BHT training and stats.
module branch_unit_bht
  import rv_branch_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_kill,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_zero,
  input  logic              ex_s_less,
  input  logic              ex_u_less,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_target,
  input  logic [PC_W-1:0]   ex_pc_plus4,
  output logic              cnd,
  output logic              flush,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              illegal,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  logic              cnd_c, legal_c, resolve_c, upd_c, mispred_c;
  logic              cnd_d, cnd_q, flush_d, flush_q, illegal_d, illegal_q;
  logic [PC_W-1:0]   redirect_d, redirect_q;
  logic [STAT_W-1:0] br_d, br_q, mp_d, mp_q;

  // Only the word-index bits of the PCs address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  bht_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_pc[IDX_W+1:2]),
    .rd_taken_c(if_pred_taken),
    .wr_en     (upd_c),
    .wr_idx    (ex_pc[IDX_W+1:2]),
    .wr_taken  (cnd_c)
  );

  // Condition from ALU flags; funct3[0] inverts the sense (BNE/BGE/BGEU).
  always_comb begin
    cnd_c   = 1'b0;
    legal_c = 1'b1;
    case (ex_funct3[2:1])
      2'b00:   cnd_c = ex_funct3[0] ^ ex_zero;
      2'b10:   cnd_c = ex_funct3[0] ^ ex_s_less;
      2'b11:   cnd_c = ex_funct3[0] ^ ex_u_less;
      default: legal_c = 1'b0;
    endcase
  end

  assign resolve_c = ex_valid & ex_branch & ~ex_kill;
  assign upd_c     = resolve_c & legal_c;
  assign mispred_c = cnd_c ^ ex_pred_taken;

  always_comb begin
    cnd_d      = upd_c & cnd_c;
    flush_d    = upd_c & mispred_c;
    illegal_d  = resolve_c & ~legal_c;
    redirect_d = redirect_q;
    br_d       = br_q;
    mp_d       = mp_q;
    if (upd_c) begin
      redirect_d = cnd_c ? ex_target : ex_pc_plus4;
      if (br_q != '1) br_d = br_q + STAT_W'(1);
      if (mispred_c && mp_q != '1) mp_d = mp_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnd_q      <= 1'b0;
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      redirect_q <= '0;
      br_q       <= '0;
      mp_q       <= '0;
    end else begin
      cnd_q      <= cnd_d;
      flush_q    <= flush_d;
      illegal_q  <= illegal_d;
      redirect_q <= redirect_d;
      br_q       <= br_d;
      mp_q       <= mp_d;
    end
  end

  assign cnd              = cnd_q;
  assign flush            = flush_q;
  assign illegal          = illegal_q;
  assign redirect_pc      = redirect_q;
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;

endmodule

// File: tb/tb_branch_unit_bht.sv
// Directed scoreboard bench for branch_unit_bht (STAT_W=4 to reach stat saturation).
module tb_branch_unit_bht;

  localparam int unsigned PC_W = 32, IDX_W = 6, CNT_W = 2, STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   if_pc;
  logic              if_pred_taken;
  logic              ex_valid, ex_branch, ex_kill;
  logic [2:0]        ex_funct3;
  logic              ex_zero, ex_s_less, ex_u_less;
  logic [PC_W-1:0]   ex_pc, ex_target, ex_pc_plus4;
  logic              ex_pred_taken;
  logic              cnd, flush, illegal;
  logic [PC_W-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;

  branch_unit_bht #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_kill(ex_kill),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_s_less(ex_s_less),
    .ex_u_less(ex_u_less), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ex_target(ex_target), .ex_pc_plus4(ex_pc_plus4), .cnd(cnd), .flush(flush),
    .redirect_pc(redirect_pc), .illegal(illegal), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cnd;
    logic        flush;
    logic        illegal;
    logic [31:0] redir;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          bht_m[64];
  int          br_m, mp_m;
  logic [31:0] redir_m;

  function automatic logic ref_cnd(input logic [2:0] f3, input logic z, s, u);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      3'b110:  return u;
      3'b111:  return !u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_pred(input logic [31:0] pc);
    return bht_m[pc[7:2]] >= 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
    br_m = 0; mp_m = 0; redir_m = '0;
    sb_q.delete();
  endtask

  task automatic step_and_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_cnd"},      32'(cnd),      32'(e.cnd));
      chk({tag, "_flush"},    32'(flush),    32'(e.flush));
      chk({tag, "_illegal"},  32'(illegal),  32'(e.illegal));
      chk({tag, "_redirect"}, redirect_pc,   e.redir);
    end
    chk({tag, "_stat_br"}, 32'(stat_branches),    32'(br_m));
    chk({tag, "_stat_mp"}, 32'(stat_mispredicts), 32'(mp_m));
    chk({tag, "_pred"},    32'(if_pred_taken),    32'(model_pred(if_pc)));
  endtask

  task automatic resolve(input string tag, input logic kill, input logic [2:0] f3,
                         input logic z, s, u, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt);
    exp_t e;
    logic c;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_kill = kill; ex_funct3 = f3;
    ex_zero = z; ex_s_less = s; ex_u_less = u; ex_pc = pc;
    ex_pred_taken = pred; ex_target = tgt; ex_pc_plus4 = pc + 32'd4;
    #1;
    // The IF read must still see the table as of the last edge.
    chk({tag, "_pred_pre"}, 32'(if_pred_taken), 32'(model_pred(if_pc)));
    e = '{cnd: 1'b0, flush: 1'b0, illegal: 1'b0, redir: redir_m};
    if (!kill) begin
      if (f3[2:1] == 2'b01) begin
        e.illegal = 1'b1;
      end else begin
        c = ref_cnd(f3, z, s, u);
        e.cnd   = c;
        e.flush = (c != pred);
        redir_m = c ? tgt : pc + 32'd4;
        e.redir = redir_m;
        if (br_m < 15) br_m++;
        if (c != pred && mp_m < 15) mp_m++;
        if (c && bht_m[pc[7:2]] < 3) bht_m[pc[7:2]]++;
        if (!c && bht_m[pc[7:2]] > 0) bht_m[pc[7:2]]--;
      end
    end
    sb_q.push_back(e);
    step_and_check(tag);
  endtask

  task automatic idle(input string tag);
    ex_valid = 1'b0; ex_kill = 1'b0;
    sb_q.push_back('{cnd: 1'b0, flush: 1'b0, illegal: 1'b0, redir: redir_m});
    step_and_check(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_cnd"},     32'(cnd),              32'd0);
    chk({tag, "_flush"},   32'(flush),            32'd0);
    chk({tag, "_illegal"}, 32'(illegal),          32'd0);
    chk({tag, "_redir"},   redirect_pc,           32'd0);
    chk({tag, "_stat_br"}, 32'(stat_branches),    32'd0);
    chk({tag, "_stat_mp"}, 32'(stat_mispredicts), 32'd0);
    chk({tag, "_pred"},    32'(if_pred_taken),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    ex_valid = 0; ex_branch = 0; ex_kill = 0; ex_funct3 = 0;
    ex_zero = 0; ex_s_less = 0; ex_u_less = 0; ex_pc = 0;
    ex_pred_taken = 0; ex_target = 0; ex_pc_plus4 = 0;
    if_pc = 32'h40;
    rst_n = 1'b1;
    #2;
    pulse_reset("reset");

    // First mispredict: BEQ taken against a not-taken prediction.
    resolve("beq40", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h80);
    chk("beq40_redirect_abs", redirect_pc, 32'h80);
    chk("beq40_mp_abs", 32'(stat_mispredicts), 32'd1);
    chk("beq40_pred_abs", 32'(if_pred_taken), 32'd1);
    idle("beq40_idle");

    // Counter saturation at 11 and at 00.
    if_pc = 32'h8;
    for (int i = 0; i < 4; i++) resolve("sat_up", 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, 32'h100);
    for (int i = 0; i < 5; i++) resolve("sat_dn", 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 32'h100);
    resolve("sat_chk", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h8, 1'b0, 32'h100);
    chk("sat_floor_pred", 32'(if_pred_taken), 32'd0);
    idle("sat_idle");

    pulse_reset("reset2");
    // Condition sweep over legal funct3 and all flag combinations.
    begin
      logic [2:0] legal_f3 [6];
      legal_f3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      for (int f = 0; f < 6; f++) begin
        for (int k = 0; k < 8; k++) begin
          logic [2:0] fl;
          fl = 3'(k);
          if_pc = 32'h1000 + 32'(f * 4);
          resolve("sweep", 1'b0, legal_f3[f], fl[0], fl[1], fl[2],
                  32'h1000 + 32'(f * 4), 1'($urandom_range(0, 1)),
                  32'h2000 + 32'(f * 64 + k * 4));
        end
      end
    end
    resolve("bgeu_nt", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h900);
    chk("bgeu_nt_cnd", 32'(cnd), 32'd0);
    chk("bgeu_nt_redirect", redirect_pc, 32'h304);
    idle("sweep_idle");

    // Reserved funct3: one-cycle illegal pulse, no side effects.
    if_pc = 32'h500;
    resolve("rsv010", 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 32'h600);
    idle("rsv010_after");
    resolve("rsv011", 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 32'h600);
    idle("rsv011_after");

    // Kill suppresses a mispredicting BLT; then same-index read/write collision.
    pulse_reset("reset3");
    if_pc = 32'h100;
    resolve("kill_blt", 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h400);
    resolve("collide", 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'h400);
    chk("collide_new_pred", 32'(if_pred_taken), 32'd1);
    idle("collide_idle");

    // Stats saturation, then asynchronous reset with a flush pending.
    if_pc = 32'h200;
    for (int i = 0; i < 20; i++) resolve("statsat", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h200, 1'b0, 32'h700);
    chk("statsat_br15", 32'(stat_branches), 32'd15);
    chk("statsat_mp15", 32'(stat_mispredicts), 32'd15);
    #2;
    pulse_reset("midreset");
    resolve("post_rst", 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h700);
    chk("post_rst_entry_10", 32'(if_pred_taken), 32'd1);
    idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
